// File: rtl/cpu_oci_debug_mem.sv
// Purpose: on-chip debug RAM shared by the JTAG monitor path and the CPU debug slave port.
// Latency: JTAG read 2 cycles to MonDReg, JTAG write 1 cycle; CPU RAM read 2 cycles, RAM write/control access 1 cycle.
// Backpressure: JTAG always wins the single RAM port; the CPU sees waitrequest while a JTAG access owns it.
module cpu_oci_debug_mem #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    J_RD  = 2'd1,
    J_CAP = 2'd2,
    C_RD  = 2'd3
  } state_t;

  // RAM preload is handled by the implementation flow; the file name is only carried through.
  localparam bit HAS_INIT_FILE = (INIT_FILE != "");

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   mon_areg;
  logic [31:0]         mem [2**ADDR_W];
  logic [31:0]         ram_q;

  logic                jtag_window;
  logic                take_a, take_na, take_b, jtag_take;
  logic                ctrl_sel;
  logic                cpu_slot;
  logic                cpu_ram_rd, cpu_ctrl_rd, cpu_ram_wr, cpu_ctrl_wr;
  logic                crd_done;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [31:0]         jdo_data;
  logic [31:0]         ctrl_word;

  logic                ram_re, ram_we, ram_we_gated;
  logic [3:0]          ram_be;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_wdata;

  logic                unused_bits;
  assign unused_bits = ^{jdo[37:36], jdo[2:0], HAS_INIT_FILE};

  assign jdo_addr  = jdo[26 +: ADDR_W];
  assign jdo_data  = jdo[34:3];
  assign ctrl_sel  = address[ADDR_W];
  assign ctrl_word = {29'b0, monitor_go, monitor_error, monitor_ready};

  // Strobes are honoured only when no JTAG access is in flight; a > no_action_a > b.
  assign jtag_window = (state == IDLE) || (state == C_RD);
  assign take_a      = take_action_ocimem_a & jtag_window;
  assign take_na     = take_no_action_ocimem_a & ~take_action_ocimem_a & jtag_window;
  assign take_b      = take_action_ocimem_b & ~take_action_ocimem_a
                       & ~take_no_action_ocimem_a & jtag_window;
  assign jtag_take   = take_a | take_na | take_b;

  // A new CPU access starts only from IDLE with the port free of JTAG; read beats write.
  assign cpu_slot    = (state == IDLE) & ~jtag_take;
  assign cpu_ram_rd  = cpu_slot & read & ~ctrl_sel;
  assign cpu_ctrl_rd = cpu_slot & read & ctrl_sel;
  assign cpu_ram_wr  = cpu_slot & write & ~read & ~ctrl_sel & debugaccess;
  assign cpu_ctrl_wr = cpu_slot & write & ~read & ctrl_sel;
  assign crd_done    = (state == C_RD) & ~jtag_take;

  // Next-state and waitrequest; a JTAG strobe in C_RD throws the CPU read away so it restarts.
  always_comb begin
    state_nxt   = state;
    waitrequest = 1'b0;
    case (state)
      IDLE, C_RD: begin
        if (take_a) begin
          waitrequest = 1'b1;
          state_nxt   = jdo[35] ? J_RD : IDLE;
        end else if (take_na) begin
          waitrequest = 1'b1;
          state_nxt   = J_RD;
        end else if (take_b) begin
          waitrequest = 1'b1;
          state_nxt   = IDLE;
        end else if (state == C_RD) begin
          state_nxt   = IDLE;
        end else if (cpu_ram_rd) begin
          waitrequest = 1'b1;
          state_nxt   = C_RD;
        end
      end
      J_RD: begin
        waitrequest = 1'b1;
        state_nxt   = J_CAP;
      end
      J_CAP: begin
        waitrequest = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single RAM port arbitration: JTAG requests first, then the CPU.
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = mon_areg;
    ram_wdata = jdo_data;
    if (take_a) begin
      ram_re   = jdo[35];
      ram_addr = jdo_addr;
    end else if (take_na) begin
      ram_re   = 1'b1;
    end else if (take_b) begin
      ram_we   = 1'b1;
      ram_be   = 4'hF;
    end else if (cpu_ram_rd) begin
      ram_re   = 1'b1;
      ram_addr = address[ADDR_W-1:0];
    end else if (cpu_ram_wr) begin
      ram_we    = 1'b1;
      ram_be    = byteenable;
      ram_addr  = address[ADDR_W-1:0];
      ram_wdata = writedata;
    end
  end

  // Reset must never let a half-issued write land in the RAM.
  assign ram_we_gated = ram_we & reset_n;

  // RAM array with byte-lane writes and a registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_gated) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_re) ram_q <= mem[ram_addr];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Monitor address/data registers: load on command, capture on read, advance after each access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_areg <= '0;
      MonDReg  <= '0;
    end else if (take_a) begin
      mon_areg <= jdo_addr;
    end else if (take_b) begin
      mon_areg <= mon_areg + ADDR_W'(1);
      MonDReg  <= jdo_data;
    end else if (state == J_RD) begin
      mon_areg <= mon_areg + ADDR_W'(1);
      MonDReg  <= ram_q;
    end
  end

  // CPU read data: control word in the accepting cycle, RAM data when C_RD completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         readdata <= '0;
    else if (cpu_ctrl_rd) readdata <= ctrl_word;
    else if (crd_done)    readdata <= ram_q;
  end

  // Monitor handshake flags; a JTAG clear overrides any CPU set in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
    end else begin
      if (take_a && jdo[24])               monitor_ready <= 1'b0;
      else if (cpu_ctrl_wr && writedata[0]) monitor_ready <= 1'b1;
      if (take_a && jdo[24])               monitor_error <= 1'b0;
      else if (cpu_ctrl_wr && writedata[1]) monitor_error <= 1'b1;
      if (take_a && jdo[23])               monitor_go    <= 1'b1;
      else if (cpu_ctrl_wr && writedata[2]) monitor_go    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_oci_debug_mem.sv
// Purpose: directed plus randomized check of the debug RAM against a word-level reference model.
// Latency: follows the JTAG/CPU access timings cycle by cycle.
// Backpressure: CPU accesses are held until waitrequest drops, within a bounded cycle budget.
module tb_cpu_oci_debug_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [8:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        monitor_go;

  cpu_oci_debug_mem #(.ADDR_W(8), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .monitor_go(monitor_go)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus monitor registers and flags.
  logic [31:0] mem_m [256];
  logic [7:0]  areg_m = '0;
  logic [31:0] dreg_m = '0;
  logic        rdy_m = 1'b0, err_m = 1'b0, go_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ready"}, {31'b0, monitor_ready}, {31'b0, rdy_m});
    chk({tag, "_error"}, {31'b0, monitor_error}, {31'b0, err_m});
    chk({tag, "_go"},    {31'b0, monitor_go},    {31'b0, go_m});
  endtask

  task automatic jtag_a(input logic [7:0] a, input bit rd, input bit clr, input bit go);
    jdo = '0;
    jdo[33:26] = a;
    jdo[35] = rd;
    jdo[24] = clr;
    jdo[23] = go;
    take_action_ocimem_a = 1'b1;
    #1 chk("jtag_a_wait", {31'b0, waitrequest}, 32'd1);
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    areg_m = a;
    if (clr) begin rdy_m = 1'b0; err_m = 1'b0; end
    if (go) go_m = 1'b1;
    chk("jtag_a_dreg_hold", MonDReg, dreg_m);
    tick();
    if (rd) begin
      dreg_m = mem_m[a];
      areg_m = a + 8'd1;
      chk("jtag_a_rd", MonDReg, dreg_m);
    end
    tick();
    chk_flags("jtag_a");
  endtask

  task automatic jtag_na();
    take_no_action_ocimem_a = 1'b1;
    #1 chk("jtag_na_wait", {31'b0, waitrequest}, 32'd1);
    tick();
    take_no_action_ocimem_a = 1'b0;
    chk("jtag_na_dreg_hold", MonDReg, dreg_m);
    tick();
    dreg_m = mem_m[areg_m];
    areg_m = areg_m + 8'd1;
    chk("jtag_na_rd", MonDReg, dreg_m);
    tick();
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    #1 chk("jtag_b_wait", {31'b0, waitrequest}, 32'd1);
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    mem_m[areg_m] = d;
    dreg_m = d;
    areg_m = areg_m + 8'd1;
    chk("jtag_b_dreg", MonDReg, dreg_m);
    tick();
    tick();
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input bit dbg);
    address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
    #1 chk("cpu_wr_ack", {31'b0, waitrequest}, 32'd0);
    tick();
    write = 1'b0;
    if (a[8]) begin
      if (d[0]) rdy_m = 1'b1;
      if (d[1]) err_m = 1'b1;
      if (d[2]) go_m = 1'b0;
    end else if (dbg) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[a[7:0]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic cpu_read(input logic [8:0] a, input bit wr_too);
    logic [31:0] exp;
    int waits;
    bit done;
    exp = a[8] ? {29'b0, go_m, err_m, rdy_m} : mem_m[a[7:0]];
    address = a; read = 1'b1; write = wr_too; writedata = 32'h7; debugaccess = 1'b1;
    byteenable = 4'hF;
    waits = 0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!waitrequest) begin
        done = 1'b1;
        tick();
        break;
      end
      waits++;
      tick();
    end
    read = 1'b0; write = 1'b0;
    chk("cpu_rd_done", {31'b0, done}, 32'd1);
    chk("cpu_rd_waits", waits, a[8] ? 32'd0 : 32'd1);
    chk("cpu_rd_data", readdata, exp);
    chk_flags("cpu_rd");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time budget exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old5;
    int n;
    bit done;

    tick(); tick();
    chk("rst_dreg", MonDReg, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_dreg", MonDReg, 32'd0);
    chk("rel_readdata", readdata, 32'd0);
    chk("rel_wait", {31'b0, waitrequest}, 32'd0);
    chk_flags("rel");

    // Give every RAM word a known random value.
    for (int i = 0; i < 256; i++) cpu_write({1'b0, i[7:0]}, $urandom, 4'hF, 1'b1);

    // JTAG sequential writes, then confirm the address advanced to 0x12.
    jtag_a(8'h10, 1'b0, 1'b0, 1'b0);
    jtag_b(32'hDEADBEEF);
    jtag_b(32'h12345678);
    jtag_na();

    // JTAG read at a new address followed by a sequential read.
    jtag_a(8'h10, 1'b1, 1'b0, 1'b0);
    chk("seq_rd0", MonDReg, 32'hDEADBEEF);
    jtag_na();
    chk("seq_rd1", MonDReg, 32'h12345678);

    // JTAG preempts a CPU read in its first cycle.
    jtag_a(8'h11, 1'b0, 1'b0, 1'b0);
    address = 9'h010; read = 1'b1; take_no_action_ocimem_a = 1'b1;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!waitrequest) begin
        done = 1'b1;
        tick();
        break;
      end
      n++;
      tick();
      take_no_action_ocimem_a = 1'b0;
    end
    read = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    dreg_m = mem_m[8'h11];
    areg_m = 8'h12;
    chk("pre_done", {31'b0, done}, 32'd1);
    chk("pre_waits", n, 32'd4);
    chk("pre_dreg", MonDReg, 32'h12345678);
    chk("pre_readdata", readdata, 32'hDEADBEEF);
    tick();

    // Address wrap at the top of the RAM.
    jtag_a(8'hFF, 1'b0, 1'b0, 1'b0);
    jtag_b(32'hA5A5A5A5);
    jtag_b(32'h5A5A5A5A);
    cpu_read(9'h0FF, 1'b0);
    cpu_read(9'h000, 1'b0);
    chk("wrap_ff", mem_m[8'hFF], 32'hA5A5A5A5);

    // Control register set, then same-cycle JTAG clear beats CPU set.
    cpu_write(9'h100, 32'h3, 4'hF, 1'b0);
    chk_flags("ctrl_set");
    cpu_read(9'h100, 1'b0);
    jdo = '0; jdo[24] = 1'b1; jdo[33:26] = 8'h40;
    take_action_ocimem_a = 1'b1;
    address = 9'h100; writedata = 32'h3; write = 1'b1;
    #1 chk("clr_wait", {31'b0, waitrequest}, 32'd1);
    tick();
    take_action_ocimem_a = 1'b0; write = 1'b0; jdo = '0;
    rdy_m = 1'b0; err_m = 1'b0; areg_m = 8'h40;
    chk_flags("clr_win");
    tick(); tick();

    // monitor_go set by JTAG, cleared by CPU.
    jtag_a(8'h20, 1'b0, 1'b0, 1'b1);
    cpu_read(9'h100, 1'b0);
    cpu_write(9'h100, 32'h4, 4'hF, 1'b0);
    chk_flags("go_clr");

    // Dropped write without debugaccess, then byte-lane write.
    cpu_write(9'h010, 32'h0BADF00D, 4'hF, 1'b0);
    cpu_read(9'h010, 1'b0);
    cpu_write(9'h010, 32'h11223344, 4'b0101, 1'b1);
    cpu_read(9'h010, 1'b0);
    chk("be_merge", mem_m[8'h10], 32'hDE22BE44);

    // read and write together act as a read.
    cpu_write(9'h100, 32'h1, 4'hF, 1'b0);
    cpu_read(9'h100, 1'b1);

    // Randomized mix of JTAG and CPU traffic.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0: jtag_a(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        1: jtag_na();
        2: jtag_b($urandom);
        3: if ($urandom_range(0, 3) == 0)
             cpu_write({1'b1, 8'($urandom)}, 32'($urandom_range(0, 7)), 4'hF, 1'b0);
           else
             cpu_write({1'b0, 8'($urandom)}, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
        4: cpu_read({1'($urandom_range(0, 3) == 0), 8'($urandom)}, 1'b0);
        default: jtag_a(8'($urandom), 1'b1, 1'b0, 1'b0);
      endcase
    end

    // Reset during a JTAG write must not disturb the RAM.
    jtag_a(8'h05, 1'b0, 1'b0, 1'b0);
    old5 = mem_m[8'h05];
    jdo = '0; jdo[34:3] = 32'hFFFFFFFF;
    take_action_ocimem_b = 1'b1;
    reset_n = 1'b0;
    tick();
    take_action_ocimem_b = 1'b0; jdo = '0;
    areg_m = '0; dreg_m = '0; rdy_m = 1'b0; err_m = 1'b0; go_m = 1'b0;
    chk("rst_mid_dreg", MonDReg, 32'd0);
    chk("rst_mid_readdata", readdata, 32'd0);
    chk_flags("rst_mid");
    reset_n = 1'b1;
    tick();
    cpu_read(9'h005, 1'b0);
    chk("rst_no_write", mem_m[8'h05], old5);
    jtag_na();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_oci_debug_mem.md
Name: cpu_oci_debug_mem

Overview:
- Sits directly downstream of the JTAG debug module's system-clock stage.
- Consumes its 38-bit command word jdo and the ocimem take-action strobes, and owns the on-chip debug RAM shared with the CPU's debug slave port.
- Returns MonDReg, monitor_ready and monitor_error, which the JTAG path shifts back out to the host.
- Single-port RAM, arbitrated with JTAG priority; CPU side is an Avalon-MM slave with waitrequest.

Parameters:
- ADDR_W, 8, word-address width of debug RAM (depth 2^ADDR_W x 32).
- INIT_FILE, "", optional RAM init file; empty means none.

Ports:
- clk  in  1  system clock; sole clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  command/data word from the JTAG debug stage.
- take_action_ocimem_a  in  1  1-cycle strobe: address/control command.
- take_no_action_ocimem_a  in  1  1-cycle strobe: sequential read at current address.
- take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at current address.
- address  in  ADDR_W+1  CPU word address; MSB=1 selects control register.
- read  in  1  CPU read request.
- write  in  1  CPU write request.
- writedata  in  32  CPU write data.
- byteenable  in  4  CPU byte lanes.
- debugaccess  in  1  CPU write qualifier for RAM region.
- readdata  out  32  CPU read data.
- waitrequest  out  1  CPU stall.
- MonDReg  out  32  monitor data register, returned to the JTAG stage.
- monitor_ready  out  1  CPU-set ready flag.
- monitor_error  out  1  CPU-set error flag.
- monitor_go  out  1  level; host "resume monitor" request.

Behaviour:
- Reset: all outputs and registers are 0, MonAReg=0, FSM=IDLE. RAM contents are not reset.
- Reset is async assert and sync deassert at the consumer. Reset mid-operation aborts any JTAG or CPU access; no RAM write occurs on that edge.
- RAM: synchronous read, 1-cycle latency; one access per cycle.
- FSM states: IDLE, J_RD, J_CAP, C_RD.
- take_action_ocimem_a in IDLE/C_RD:
  - MonAReg <= jdo[33:26] (low ADDR_W bits).
  - jdo[24]=1: clear monitor_ready and monitor_error.
  - jdo[23]=1: set monitor_go.
  - jdo[35]=1: issue RAM read at the new address -> J_RD.
  - jdo[35]=0: stay IDLE.
- take_no_action_ocimem_a in IDLE/C_RD: issue read at MonAReg -> J_RD.
- J_RD -> J_CAP: MonDReg <= RAM q; MonAReg <= MonAReg+1 (mod 2^ADDR_W, 0xFF wraps to 0x00).
- J_CAP -> IDLE.
- take_action_ocimem_b in IDLE/C_RD:
  - RAM[MonAReg] <= jdo[34:3], all bytes written.
  - MonDReg <= jdo[34:3]; MonAReg <= MonAReg+1.
  - Stay IDLE (1 cycle).
- Simultaneous strobes: priority ocimem_a > no_action_a > ocimem_b; losers are dropped.
- Strobes arriving in J_RD/J_CAP are dropped. Upstream guarantees spacing of at least 3 cycles.
- JTAG access preempts CPU: a pending C_RD is aborted and restarted from IDLE. waitrequest=1 in any cycle where a JTAG strobe is taken or FSM is in J_RD/J_CAP.
- CPU RAM read: cycle 1 in IDLE issues read, waitrequest=1 -> C_RD; cycle 2 readdata <= q, waitrequest=0 -> IDLE. Total latency 2 cycles.
- CPU RAM write:
  - Completes in 1 cycle (waitrequest=0) when IDLE with no JTAG strobe.
  - Byte lanes per byteenable.
  - Performed only if debugaccess=1; otherwise dropped, still acked.
- Control register (address MSB=1):
  - Read returns {29'b0, monitor_go, monitor_error, monitor_ready} in 1 cycle, waitrequest=0.
  - Write: bit0=1 sets monitor_ready; bit1=1 sets monitor_error; bit2=1 clears monitor_go. debugaccess is not required.
- Same-cycle JTAG clear (jdo[24]) and CPU set of a flag: JTAG clear wins.
- read and write both high: treated as read.
- MonDReg holds its value until the next JTAG read capture or write.

Test Plan:
- Reset release -> MonDReg=0, readdata=0, waitrequest=0, monitor_ready/error/go=0.
- ocimem_a jdo[33:26]=0x10, jdo[35]=0; then ocimem_b ×2 with data 0xDEADBEEF and 0x12345678 -> RAM[0x10]=0xDEADBEEF, RAM[0x11]=0x12345678, MonAReg=0x12.
- ocimem_a addr 0x10, jdo[35]=1; then no_action_a -> MonDReg=0xDEADBEEF 2 cycles after the first strobe, 0x12345678 after the second, MonAReg=0x12.
- ocimem_a addr 0xFF; ocimem_b 0xA5A5A5A5; ocimem_b 0x5A5A5A5A -> RAM[0xFF]=0xA5A5A5A5, RAM[0x00]=0x5A5A5A5A (wrap).
- CPU read of 0x10 with a take_no_action_ocimem_a in its first cycle -> waitrequest held until the JTAG read completes, then readdata=0xDEADBEEF after 2 further cycles.
- CPU write ctrl=0x3 -> ready=error=1; same cycle as ocimem_a jdo[24]=1 -> both remain 0. CPU RAM write with debugaccess=0 to 0x10 -> RAM unchanged, 1-cycle ack.
